// File: rtl/axi_pkg.sv
// Shared AXI read-channel types: burst encodings, response codes and the
// read-slave sequencing states.
package axi_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'd0,
        INCR  = 2'd1,
        WRAP  = 2'd2,
        RSVD  = 2'd3
    } axi_burst_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'd0;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } axi_state_t;

    // WRAP bursts are only defined for 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_r_skid_buffer.sv
// Two-entry R-channel buffer of {id, data, resp, last}; head entry drives the
// outputs directly so they hold steady while the consumer stalls.
module axi_r_skid_buffer #(
    parameter int ID_W   = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [ID_W-1:0]   i_id,
    input  logic [DATA_W-1:0] i_data,
    input  logic [1:0]        i_resp,
    input  logic              i_last,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [ID_W-1:0]   o_id,
    output logic [DATA_W-1:0] o_data,
    output logic [1:0]        o_resp,
    output logic              o_last,
    output logic [1:0]        o_count
);

    localparam int EW = ID_W + DATA_W + 3;

    logic [EW-1:0] r_ent0;
    logic [EW-1:0] r_ent1;
    logic [1:0]    r_cnt;
    logic [EW-1:0] w_in;
    logic          w_push;
    logic          w_pop;

    assign w_in    = {i_id, i_data, i_resp, i_last};
    assign o_valid = (r_cnt != 2'd0);
    assign o_ready = (r_cnt != 2'd2) || i_ready;
    assign w_push  = i_valid && o_ready;
    assign w_pop   = o_valid && i_ready;
    assign o_count = r_cnt;

    assign {o_id, o_data, o_resp, o_last} = r_ent0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ent0 <= '0;
            r_ent1 <= '0;
            r_cnt  <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) r_ent0 <= w_in;
                    else               r_ent1 <= w_in;
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_ent0 <= r_ent1;
                    r_cnt  <= r_cnt - 2'd1;
                end
                2'b11: begin
                    // Occupancy is unchanged; the new entry lands behind whatever remains.
                    if (r_cnt == 2'd1) begin
                        r_ent0 <= w_in;
                    end else begin
                        r_ent0 <= r_ent1;
                        r_ent1 <= w_in;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/axi_rom_slave_addr16_data8_id4.sv
// AXI4 read-only slave over a byte-wide synchronous memory with a side write
// port. One burst outstanding; beats flow memory -> read stage -> skid buffer.
module axi_rom_slave_addr16_data8_id4
    import axi_pkg::*;
#(
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 8,
    parameter int ID_W          = 4,
    parameter int MEM_DEPTH     = 65536,
    parameter int ARREADY_DELAY = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              axi_arvalid,
    output logic              axi_arready,
    input  logic [ID_W-1:0]   axi_arid,
    input  logic [ADDR_W-1:0] axi_araddr,
    input  logic [7:0]        axi_arlen,
    input  logic [1:0]        axi_arsize,
    input  logic [1:0]        axi_arburst,
    output logic              axi_rvalid,
    input  logic              axi_rready,
    output logic [ID_W-1:0]   axi_rid,
    output logic [DATA_W-1:0] axi_rdata,
    output logic [1:0]        axi_rresp,
    output logic              axi_rlast,
    input  logic              mem_wr_en,
    input  logic [ADDR_W-1:0] mem_wr_addr,
    input  logic [DATA_W-1:0] mem_wr_data
);

    localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int DLY_W  = $clog2(ARREADY_DELAY + 2);

    axi_state_t        r_state;
    logic [ID_W-1:0]   r_id;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_len;
    axi_burst_t        r_burst;
    logic              r_berr;
    logic [8:0]        r_left;
    logic              r_arready;
    logic [DLY_W-1:0]  r_dly;

    logic              r_rd_vld;
    logic              r_rd_last;
    logic              r_rd_err;
    logic [DATA_W-1:0] r_mem_q;
    logic [DATA_W-1:0] r_mem [MEM_DEPTH];

    logic [ADDR_W-1:0] w_wrap_mask;
    logic [ADDR_W-1:0] w_next_addr;
    logic              w_beat_err;
    logic              w_ar_hs;
    logic              w_pop;
    logic              w_buf_ready;
    logic [1:0]        w_buf_cnt;
    logic              w_buf_drains;
    logic              w_room;
    logic              w_issue;
    logic              w_dly_done;
    logic              w_burst_bad;
    logic [DATA_W-1:0] w_push_data;
    logic [1:0]        w_push_resp;

    assign axi_arready = r_arready;
    assign w_ar_hs     = axi_arvalid && r_arready;
    assign w_pop       = axi_rvalid && axi_rready;
    assign w_dly_done  = (32'(r_dly) + 32'd1 >= ARREADY_DELAY);

    assign w_burst_bad = (axi_arsize != 2'd0) ||
                         (axi_arburst == RSVD) ||
                         ((axi_arburst == WRAP) && !wrap_len_ok(axi_arlen));

    // WRAP windows are aligned to arlen+1 bytes, so arlen itself is the offset mask.
    assign w_wrap_mask = {{(ADDR_W-8){1'b0}}, r_len};

    always_comb begin
        w_next_addr = r_addr + ADDR_W'(1);
        case (r_burst)
            FIXED:   w_next_addr = r_addr;
            WRAP:    w_next_addr = (r_addr & ~w_wrap_mask) |
                                   ((r_addr + ADDR_W'(1)) & w_wrap_mask);
            default: w_next_addr = r_addr + ADDR_W'(1);
        endcase
    end

    assign w_beat_err = r_berr || (32'(r_addr) >= MEM_DEPTH);

    // Room = buffer occupancy (after this cycle's pop) plus in-flight reads < 2.
    assign w_buf_drains = (w_buf_cnt == 2'd0) || ((w_buf_cnt == 2'd1) && w_pop);
    assign w_room       = r_rd_vld ? w_buf_drains : w_buf_ready;
    assign w_issue      = (r_state == BURST) && w_room;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_arready <= 1'b0;
            r_dly     <= '0;
            r_id      <= '0;
            r_addr    <= '0;
            r_len     <= '0;
            r_burst   <= FIXED;
            r_berr    <= 1'b0;
            r_left    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_ar_hs) begin
                        r_id      <= axi_arid;
                        r_addr    <= axi_araddr;
                        r_len     <= axi_arlen;
                        r_burst   <= axi_burst_t'(axi_arburst);
                        r_berr    <= w_burst_bad;
                        r_left    <= {1'b0, axi_arlen} + 9'd1;
                        r_arready <= 1'b0;
                        r_state   <= BURST;
                    end else if (!r_arready) begin
                        r_dly     <= r_dly + DLY_W'(1);
                        r_arready <= w_dly_done;
                    end
                end
                BURST: begin
                    if (w_issue) begin
                        r_addr <= w_next_addr;
                        r_left <= r_left - 9'd1;
                        if (r_left == 9'd1) r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_pop && axi_rlast) begin
                        r_dly     <= '0;
                        r_arready <= (ARREADY_DELAY == 0);
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_vld  <= 1'b0;
            r_rd_last <= 1'b0;
            r_rd_err  <= 1'b0;
        end else begin
            r_rd_vld <= w_issue;
            if (w_issue) begin
                r_rd_last <= (r_left == 9'd1);
                r_rd_err  <= w_beat_err;
            end
        end
    end

    // Memory survives reset; non-blocking read and write give read-first behaviour.
    always_ff @(posedge clk) begin
        if (mem_wr_en && (32'(mem_wr_addr) < MEM_DEPTH))
            r_mem[mem_wr_addr[MEM_AW-1:0]] <= mem_wr_data;
        if (w_issue)
            r_mem_q <= r_mem[r_addr[MEM_AW-1:0]];
    end

    assign w_push_data = r_rd_err ? '0 : r_mem_q;
    assign w_push_resp = r_rd_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;

    axi_r_skid_buffer #(
        .ID_W   (ID_W),
        .DATA_W (DATA_W)
    ) u_rbuf (
        .clk     (clk),
        .rst     (reset),
        .i_valid (r_rd_vld),
        .o_ready (w_buf_ready),
        .i_id    (r_id),
        .i_data  (w_push_data),
        .i_resp  (w_push_resp),
        .i_last  (r_rd_last),
        .o_valid (axi_rvalid),
        .i_ready (axi_rready),
        .o_id    (axi_rid),
        .o_data  (axi_rdata),
        .o_resp  (axi_rresp),
        .o_last  (axi_rlast),
        .o_count (w_buf_cnt)
    );

endmodule

// File: tb/tb_axi_rom_slave_addr16_data8_id4.sv
// Bench for the AXI ROM slave: a default instance and a 256-byte,
// 5-cycle-arready-delay instance, checked against a beat-level memory model.
module tb_axi_rom_slave_addr16_data8_id4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        arvalid;
    logic [3:0]  arid;
    logic [15:0] araddr;
    logic [7:0]  arlen;
    logic [1:0]  arsize;
    logic [1:0]  arburst;
    logic        rready;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        sel;

    logic       arready0, rvalid0, rlast0, arready1, rvalid1, rlast1;
    logic [3:0] rid0, rid1;
    logic [7:0] rdata0, rdata1;
    logic [1:0] rresp0, rresp1;

    logic       o_arready, o_rvalid, o_rlast;
    logic [3:0] o_rid;
    logic [7:0] o_rdata;
    logic [1:0] o_rresp;

    assign o_arready = sel ? arready1 : arready0;
    assign o_rvalid  = sel ? rvalid1  : rvalid0;
    assign o_rlast   = sel ? rlast1   : rlast0;
    assign o_rid     = sel ? rid1     : rid0;
    assign o_rdata   = sel ? rdata1   : rdata0;
    assign o_rresp   = sel ? rresp1   : rresp0;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] mem_m [65536];

    axi_rom_slave_addr16_data8_id4 u_dut0 (
        .clk(clk), .reset(reset),
        .axi_arvalid(arvalid && !sel), .axi_arready(arready0),
        .axi_arid(arid), .axi_araddr(araddr), .axi_arlen(arlen),
        .axi_arsize(arsize), .axi_arburst(arburst),
        .axi_rvalid(rvalid0), .axi_rready(rready), .axi_rid(rid0),
        .axi_rdata(rdata0), .axi_rresp(rresp0), .axi_rlast(rlast0),
        .mem_wr_en(wr_en), .mem_wr_addr(wr_addr), .mem_wr_data(wr_data)
    );

    axi_rom_slave_addr16_data8_id4 #(.MEM_DEPTH(256), .ARREADY_DELAY(5)) u_dut1 (
        .clk(clk), .reset(reset),
        .axi_arvalid(arvalid && sel), .axi_arready(arready1),
        .axi_arid(arid), .axi_araddr(araddr), .axi_arlen(arlen),
        .axi_arsize(arsize), .axi_arburst(arburst),
        .axi_rvalid(rvalid1), .axi_rready(rready), .axi_rid(rid1),
        .axi_rdata(rdata1), .axi_rresp(rresp1), .axi_rlast(rlast1),
        .mem_wr_en(wr_en), .mem_wr_addr(wr_addr), .mem_wr_data(wr_data)
    );

    function automatic int beat_addr(input int a, input int len, input int burst, input int k);
        int base;
        if (burst == 0) return a;
        if (burst == 2) begin
            base = a - (a % (len + 1));
            return base + ((a - base + k) % (len + 1));
        end
        return (a + k) % 65536;
    endfunction

    // {resp, data} the beat k of a burst must carry, given current model memory.
    function automatic logic [9:0] exp_beat(input logic s, input int a, input int len,
                                            input int size, input int burst, input int k);
        int ad;
        bit bad;
        bad = (size != 0) || (burst == 3) ||
              (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
        ad = beat_addr(a, len, burst, k);
        if (bad || ad >= (s ? 256 : 65536)) return {2'd2, 8'd0};
        return {2'd0, mem_m[ad]};
    endfunction

    task automatic do_burst(input logic s, input logic [3:0] id, input int a, input int len,
                            input int size, input int burst, input int mode,
                            input int wr_val, input int abort_k,
                            output int ar_cyc, output int last_cyc);
        logic [9:0]  e [256];
        logic [14:0] got, want;
        int t, k, hs, prev;
        bit stalled;
        for (int i = 0; i <= len; i++) e[i] = exp_beat(s, a, len, size, burst, i);
        sel = s; arid = id; araddr = a[15:0]; arlen = len[7:0];
        arsize = size[1:0]; arburst = burst[1:0]; arvalid = 1'b1; rready = 1'b0;
        #1;
        t = 0;
        while (!o_arready && t < 60) begin @(posedge clk); #1; t++; end
        ar_cyc = cyc; last_cyc = cyc;
        n_checks++;
        if (o_arready !== 1'b1) begin
            $display("FAIL ar_wait addr=%h arready=%b want 1 within 60 cycles", a, o_arready);
            arvalid = 1'b0;
            return;
        end else n_pass++;
        @(posedge clk); #1;
        arvalid = 1'b0;
        hs = cyc;
        if (wr_val >= 0) begin
            // Lands on the same edge as the first read: beat 0 keeps the old byte.
            wr_en = 1'b1; wr_addr = a[15:0]; wr_data = wr_val[7:0];
            mem_m[a] = wr_val[7:0];
            for (int i = 1; i <= len; i++) e[i] = exp_beat(s, a, len, size, burst, i);
        end
        k = 0; prev = hs; stalled = 1'b0; t = 0;
        while (k <= len && t < 400) begin
            if (k == abort_k) begin
                reset = 1'b1;
                #1;
                n_checks++;
                if ({o_rvalid, o_arready, o_rlast, o_rid, o_rdata, o_rresp} !== 17'd0)
                    $display("FAIL reset_mid_burst got rvalid=%b arready=%b rlast=%b rid=%h rdata=%h rresp=%h want all 0",
                             o_rvalid, o_arready, o_rlast, o_rid, o_rdata, o_rresp);
                else n_pass++;
                return;
            end
            rready = (mode == 0) ? 1'b1 : (mode == 1) ? ((t % 3) == 0) : 1'($urandom % 2);
            if (o_rvalid) begin
                got  = {o_rid, o_rdata, o_rresp, o_rlast};
                want = {id, e[k][7:0], e[k][9:8], (k == len)};
                n_checks++;
                if (got !== want)
                    $display("FAIL beat addr=%h k=%0d got rid=%h data=%h resp=%h last=%b want rid=%h data=%h resp=%h last=%b",
                             a, k, got[14:11], got[10:3], got[2:1], got[0],
                             want[14:11], want[10:3], want[2:1], want[0]);
                else n_pass++;
                if (mode == 0) begin
                    n_checks++;
                    if (cyc - prev !== ((k == 0) ? 2 : 1))
                        $display("FAIL beat_timing addr=%h k=%0d gap=%0d want %0d",
                                 a, k, cyc - prev, (k == 0) ? 2 : 1);
                    else n_pass++;
                end
            end else if (stalled) begin
                n_checks++;
                $display("FAIL rvalid_dropped addr=%h k=%0d rvalid=0 want 1", a, k);
            end
            if (o_rvalid && rready) begin
                prev = cyc; last_cyc = cyc + 1; k++; stalled = 1'b0;
            end else begin
                stalled = o_rvalid;
            end
            @(posedge clk); #1;
            wr_en = 1'b0;
            t++;
        end
        rready = 1'b0;
        n_checks++;
        if (k <= len) $display("FAIL burst_timeout addr=%h beats=%0d want %0d", a, k, len + 1);
        else n_pass++;
        n_checks++;
        if (o_rvalid !== 1'b0) $display("FAIL extra_beat addr=%h rvalid=%b want 0", a, o_rvalid);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1; arvalid = 1'b0; rready = 1'b0; wr_en = 1'b0; sel = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
        wr_addr = '0; wr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({arready0, rvalid0, rlast0, rid0, rdata0, rresp0} !== 17'd0)
            $display("FAIL reset_dut0 got %h want 0", {arready0, rvalid0, rlast0, rid0, rdata0, rresp0});
        else n_pass++;
        n_checks++;
        if ({arready1, rvalid1, rlast1, rid1, rdata1, rresp1} !== 17'd0)
            $display("FAIL reset_dut1 got %h want 0", {arready1, rvalid1, rlast1, rid1, rdata1, rresp1});
        else n_pass++;
        reset = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (arready0 !== 1'b1) $display("FAIL arready_after_reset dut0 got %b want 1", arready0);
        else n_pass++;
        n_checks++;
        if (arready1 !== 1'b0) $display("FAIL arready_delay_early dut1 got %b want 0", arready1);
        else n_pass++;
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (arready1 !== 1'b1) $display("FAIL arready_delay_reached dut1 got %b want 1", arready1);
        else n_pass++;
    endtask

    task automatic preload();
        for (int i = 0; i < 528; i++) begin
            int ad;
            ad = (i < 512) ? i : (65536 - 528 + i);
            wr_en = 1'b1; wr_addr = ad[15:0]; wr_data = ad[7:0] ^ 8'h5A;
            mem_m[ad] = ad[7:0] ^ 8'h5A;
            @(posedge clk); #1;
        end
        wr_en = 1'b0;
    endtask

    task automatic test_incr();
        int a, l;
        do_burst(1'b0, 4'h7, 'h10, 3, 0, 1, 0, -1, -1, a, l);
        do_burst(1'b0, 4'h2, 'hFFFE, 3, 0, 1, 0, -1, -1, a, l);
        do_burst(1'b0, 4'h9, 'h100, 0, 0, 1, 0, -1, -1, a, l);
    endtask

    task automatic test_stall();
        int a, l;
        do_burst(1'b0, 4'h7, 'h10, 3, 0, 1, 1, -1, -1, a, l);
        do_burst(1'b0, 4'h3, 'h80, 9, 0, 1, 2, -1, -1, a, l);
        do_burst(1'b1, 4'h4, 'h40, 5, 0, 1, 1, -1, -1, a, l);
    endtask

    task automatic test_wrap();
        int a, l;
        do_burst(1'b0, 4'h1, 'h0E, 3, 0, 2, 0, -1, -1, a, l);
        do_burst(1'b0, 4'h5, 'h05, 2, 0, 2, 0, -1, -1, a, l);
        do_burst(1'b0, 4'hA, 'h33, 7, 0, 2, 2, -1, -1, a, l);
        do_burst(1'b0, 4'hB, 'h1A5, 15, 0, 2, 0, -1, -1, a, l);
    endtask

    task automatic test_errors();
        int a, l;
        do_burst(1'b0, 4'hC, 'h20, 2, 1, 1, 0, -1, -1, a, l);
        do_burst(1'b0, 4'hD, 'h20, 3, 0, 3, 2, -1, -1, a, l);
        do_burst(1'b0, 4'hE, 'h40, 4, 0, 0, 0, -1, -1, a, l);
    endtask

    task automatic test_depth();
        int a, l;
        do_burst(1'b1, 4'h6, 'hFE, 3, 0, 1, 0, -1, -1, a, l);
    endtask

    task automatic test_back_to_back();
        int a1, l1, a2, l2;
        do_burst(1'b1, 4'h1, 'h20, 1, 0, 1, 0, -1, -1, a1, l1);
        do_burst(1'b1, 4'h2, 'h30, 2, 0, 1, 0, -1, -1, a2, l2);
        n_checks++;
        if (a2 - l1 !== 5) $display("FAIL arready_delay_gap got %0d want 5", a2 - l1);
        else n_pass++;
        do_burst(1'b0, 4'h3, 'h50, 1, 0, 1, 0, -1, -1, a1, l1);
        do_burst(1'b0, 4'h4, 'h60, 2, 0, 1, 0, -1, -1, a2, l2);
        n_checks++;
        if (a2 - l1 !== 0) $display("FAIL arready_nodelay_gap got %0d want 0", a2 - l1);
        else n_pass++;
    endtask

    task automatic test_side_write();
        int a, l;
        do_burst(1'b0, 4'h8, 'h20, 3, 0, 0, 0, 'hC3, -1, a, l);
    endtask

    task automatic test_reset_mid();
        int a, l;
        do_burst(1'b0, 4'h9, 'h70, 7, 0, 1, 0, -1, 1, a, l);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0; rready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (arready0 !== 1'b1) $display("FAIL arready_after_mid_reset got %b want 1", arready0);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (rvalid0 !== 1'b0) $display("FAIL stale_beat_after_reset cycle=%0d rvalid=%b want 0", i, rvalid0);
            else n_pass++;
            @(posedge clk); #1;
        end
        do_burst(1'b0, 4'hF, 'h70, 7, 0, 1, 0, -1, -1, a, l);
    endtask

    task automatic test_random();
        int a, l, addr, len, burst, size, s;
        for (int n = 0; n < 16; n++) begin
            s     = $urandom_range(0, 1);
            addr  = $urandom_range(0, 480);
            burst = $urandom_range(0, 2);
            size  = ($urandom_range(0, 7) == 0) ? 1 : 0;
            if (burst == 2) len = ($urandom_range(0, 4) == 0) ? 2 : ((1 << $urandom_range(1, 4)) - 1);
            else            len = $urandom_range(0, 15);
            do_burst(s[0], 4'($urandom), addr, len, size, burst, 2, -1, -1, a, l);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        preload();
        test_incr();
        test_stall();
        test_wrap();
        test_errors();
        test_depth();
        test_back_to_back();
        test_side_write();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
